// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I-subset control path.
//   state_t  : sequencer states of the multi-cycle control unit
//   cause_t  : trap cause codes reported on the cause output
//   OP_*     : major opcodes recognised by the sequencer
//   ALU_*    : ALU operation codes, common to the ALU and every controller
package cpu_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } cause_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;

   // States that hold a request on the shared memory port.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle.
//   master : the control unit (reads decoded fields, run and mem_ready;
//            drives memory request, datapath enables, status and counter)
//   slave  : the datapath/memory side
//   Inputs to master : run, op[6:0], func3[2:0], func7[6:0], mem_ready
//   Outputs of master: mem_req, mem_we, ir_write, pc_write, alu_src_imm,
//                      alu_ctrl[3:0], reg_write, wb_sel, busy, halt,
//                      cause[1:0], retired[CNT_W-1:0]
interface multicycle_control_unit_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic [6:0]       op;
   logic [2:0]       func3;
   logic [6:0]       func7;
   logic             mem_ready;
   logic             mem_req;
   logic             mem_we;
   logic             ir_write;
   logic             pc_write;
   logic             alu_src_imm;
   logic [3:0]       alu_ctrl;
   logic             reg_write;
   logic             wb_sel;
   logic             busy;
   logic             halt;
   logic [1:0]       cause;
   logic [CNT_W-1:0] retired;

   modport master (
      input  run, op, func3, func7, mem_ready,
      output mem_req, mem_we, ir_write, pc_write, alu_src_imm, alu_ctrl,
             reg_write, wb_sel, busy, halt, cause, retired
   );

   modport slave (
      output run, op, func3, func7, mem_ready,
      input  mem_req, mem_we, ir_write, pc_write, alu_src_imm, alu_ctrl,
             reg_write, wb_sel, busy, halt, cause, retired
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU operation decode from the instruction function fields.
//   i_func3     : instruction[14:12]
//   i_func7_5   : instruction[30]; selects SUB (R-type only) and SRA
//   i_is_rtype  : 1 for register-register ops, 0 for immediate ops
//   o_alu_ctrl  : ALU_* operation code
module alu_ctrl_decode
   import cpu_pkg::*;
(
   input  logic [2:0] i_func3,
   input  logic       i_func7_5,
   input  logic       i_is_rtype,
   output logic [3:0] o_alu_ctrl
);

   always_comb begin
      o_alu_ctrl = ALU_ADD;
      case (i_func3)
         3'b000: o_alu_ctrl = (i_is_rtype && i_func7_5) ? ALU_SUB : ALU_ADD;
         3'b001: o_alu_ctrl = ALU_SLL;
         3'b010: o_alu_ctrl = ALU_SLT;
         3'b011: o_alu_ctrl = ALU_SLTU;
         3'b100: o_alu_ctrl = ALU_XOR;
         // imm[10] of SRAI sits in func7[5], so the shift type applies to both forms
         3'b101: o_alu_ctrl = i_func7_5 ? ALU_SRA : ALU_SRL;
         3'b110: o_alu_ctrl = ALU_OR;
         3'b111: o_alu_ctrl = ALU_AND;
         default: o_alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the RV32I-subset datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// drives the datapath enables and the shared memory handshake, counts
// retired instructions and halts in TRAP on an illegal opcode or a
// memory request that is not answered within TIMEOUT_CYCLES cycles.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : master side of multicycle_control_unit_if (see interface file)
module multicycle_control_unit
   import cpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   multicycle_control_unit_if.master bus
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t             r_state;
   state_t             w_next;
   logic [TMO_W-1:0]   r_tmo;
   logic               r_is_load;
   cause_t             r_cause;
   logic [CNT_W-1:0]   r_retired;

   logic               r_mem_req;
   logic               r_mem_we;
   logic               r_alu_src_imm;
   logic [3:0]         r_alu_ctrl;
   logic               r_reg_write;
   logic               r_wb_sel;
   logic               r_busy;
   logic               r_halt;

   logic               w_mem_wait;
   logic               w_tmo_hit;
   logic               w_retire;
   logic               w_is_rtype;
   logic [3:0]         w_alu_dec;
   logic               w_unused;

   // Only func7[5] carries meaning for this subset.
   assign w_unused = ^{bus.func7[6], bus.func7[4:0]};

   assign w_is_rtype = (bus.op == OP_R);
   assign w_mem_wait = is_mem_state(r_state) && !bus.mem_ready;
   // Completion in the limit cycle wins because w_mem_wait is then low.
   assign w_tmo_hit  = w_mem_wait && (r_tmo == TMO_LAST);
   assign w_retire   = (r_state == S_WB) || ((r_state == S_MEM_WR) && bus.mem_ready);

   alu_ctrl_decode u_alu_ctrl_decode (
      .i_func3    (bus.func3),
      .i_func7_5  (bus.func7[5]),
      .i_is_rtype (w_is_rtype),
      .o_alu_ctrl (w_alu_dec)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.run) w_next = S_FETCH;
         S_FETCH: begin
            if (bus.mem_ready)  w_next = S_DECODE;
            else if (w_tmo_hit) w_next = S_TRAP;
         end
         S_DECODE: begin
            case (bus.op)
               OP_R:              w_next = S_EXEC_R;
               OP_I:              w_next = S_EXEC_I;
               OP_LOAD, OP_STORE: w_next = S_ADDR;
               default:           w_next = S_TRAP;
            endcase
         end
         S_EXEC_R, S_EXEC_I: w_next = S_WB;
         S_ADDR:   w_next = r_is_load ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (bus.mem_ready)  w_next = S_WB;
            else if (w_tmo_hit) w_next = S_TRAP;
         end
         S_MEM_WR: begin
            if (bus.mem_ready)  w_next = bus.run ? S_FETCH : S_IDLE;
            else if (w_tmo_hit) w_next = S_TRAP;
         end
         S_WB:     w_next = bus.run ? S_FETCH : S_IDLE;
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_IDLE;
      endcase
   end

   // Controls are registered from the next state, so each one is a pure
   // function of the state register seen by the datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_tmo         <= '0;
         r_is_load     <= 1'b0;
         r_cause       <= CAUSE_NONE;
         r_retired     <= '0;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_alu_src_imm <= 1'b0;
         r_alu_ctrl    <= ALU_ADD;
         r_reg_write   <= 1'b0;
         r_wb_sel      <= 1'b0;
         r_busy        <= 1'b0;
         r_halt        <= 1'b0;
      end else begin
         r_state <= w_next;
         // Counter is zero whenever a mem state is entered: every exit path
         // (ready, trap, or not waiting at all) clears it.
         r_tmo   <= (w_mem_wait && !w_tmo_hit) ? r_tmo + 1'b1 : '0;
         if (r_state == S_DECODE) r_is_load <= (bus.op == OP_LOAD);
         if ((w_next == S_TRAP) && (r_state != S_TRAP))
            r_cause <= (r_state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
         if (w_retire) r_retired <= r_retired + 1'b1;

         r_mem_req     <= is_mem_state(w_next);
         r_mem_we      <= (w_next == S_MEM_WR);
         r_alu_src_imm <= (w_next == S_EXEC_I) || (w_next == S_ADDR);
         r_alu_ctrl    <= ((w_next == S_EXEC_R) || (w_next == S_EXEC_I)) ? w_alu_dec : ALU_ADD;
         r_reg_write   <= (w_next == S_WB);
         r_wb_sel      <= (w_next == S_WB) && r_is_load;
         r_busy        <= (w_next != S_IDLE) && (w_next != S_TRAP);
         r_halt        <= (w_next == S_TRAP);
      end
   end

   assign bus.mem_req     = r_mem_req;
   assign bus.mem_we      = r_mem_we;
   // The fetched word is only valid in the cycle mem_ready is high, so the
   // IR/PC strobes qualify the FETCH state with mem_ready; rst blocks the
   // write so an aborted fetch leaves IR and PC untouched.
   assign bus.ir_write    = (r_state == S_FETCH) && bus.mem_ready && !rst;
   assign bus.pc_write    = (r_state == S_FETCH) && bus.mem_ready && !rst;
   assign bus.alu_src_imm = r_alu_src_imm;
   assign bus.alu_ctrl    = r_alu_ctrl;
   assign bus.reg_write   = r_reg_write;
   assign bus.wb_sel      = r_wb_sel;
   assign bus.busy        = r_busy;
   assign bus.halt        = r_halt;
   assign bus.cause       = r_cause;
   assign bus.retired     = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. A per-instruction trace
// model builds the expected per-cycle control vector and drive values; the
// runner replays them and compares every cycle.
module tb_multicycle_control_unit;

   localparam int TMO = 16;
   localparam int CW  = 4;

   localparam logic [6:0] T_R  = 7'b0110011;
   localparam logic [6:0] T_I  = 7'b0010011;
   localparam logic [6:0] T_LD = 7'b0000011;
   localparam logic [6:0] T_ST = 7'b0100011;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_control_unit_if #(.CNT_W(CW)) bus ();

   multicycle_control_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic          rst;
      logic          run;
      logic          rdy;
      logic [6:0]    op;
      logic [2:0]    f3;
      logic [6:0]    f7;
      logic [14:0]   out;
      logic [CW-1:0] ret;
   } step_t;

   step_t       q[$];
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   logic        m_run = 1'b0;
   logic [6:0]  m_op  = '0;
   logic [2:0]  m_f3  = '0;
   logic [6:0]  m_f7  = '0;
   int          m_ret = 0;

   // {mem_req, mem_we, ir_write, pc_write, alu_src_imm, alu_ctrl,
   //  reg_write, wb_sel, busy, halt, cause}
   function automatic logic [14:0] mk(input logic mreq, input logic mwe, input logic irw,
                                      input logic imm, input logic [3:0] alu, input logic rw,
                                      input logic wbs, input logic bsy, input logic hlt,
                                      input logic [1:0] cs);
      return {mreq, mwe, irw, irw, imm, alu, rw, wbs, bsy, hlt, cs};
   endfunction

   function automatic logic [3:0] alu_exp(input logic [2:0] f3, input logic f7_5, input logic rtype);
      int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      int r;
      r = base[f3];
      if ((f3 == 3'd0 && rtype && f7_5) || (f3 == 3'd5 && f7_5)) r = r + 1;
      return 4'(r);
   endfunction

   function automatic logic is_legal(input logic [6:0] op);
      return (op == T_R) || (op == T_I) || (op == T_LD) || (op == T_ST);
   endfunction

   task automatic push(input logic rdy, input logic [14:0] o);
      step_t s;
      s.rst = 1'b0; s.run = m_run; s.rdy = rdy;
      s.op = m_op; s.f3 = m_f3; s.f7 = m_f7;
      s.out = o; s.ret = CW'(m_ret);
      q.push_back(s);
   endtask

   task automatic push_idle(input int n);
      repeat (n) push(1'b0, '0);
   endtask

   task automatic start_from_idle();
      m_run = 1'b1;
      push(1'b0, '0);
   endtask

   task automatic push_trap(input int n, input logic [1:0] c);
      repeat (n) push(1'b0, mk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1, c));
   endtask

   // Assert rst in the most recently queued cycle; retired is cleared by it.
   task automatic mark_reset();
      step_t s;
      s = q.pop_back();
      s.rst = 1'b1;
      q.push_back(s);
      m_ret = 0;
   endtask

   // A memory phase of d wait cycles then ready; d >= TMO never answers.
   task automatic push_mem(input logic ifetch, input logic we, input int d, output logic to);
      logic last;
      to = (d >= TMO);
      for (int k = 0; k < (to ? TMO : d + 1); k++) begin
         last = !to && (k == d);
         push(last, mk(1, we, ifetch && last, 0, 4'd0, 0, 0, 1, 0, 2'b00));
      end
   endtask

   task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int fd, input int md, input logic run_after,
                            output logic [1:0] tc);
      logic to;
      m_op = op; m_f3 = f3; m_f7 = f7; m_run = 1'b1; tc = 2'b00;
      push_mem(1'b1, 1'b0, fd, to);
      if (to) begin tc = 2'b10; return; end
      push(1'b0, mk(0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 2'b00));
      if (!is_legal(op)) begin tc = 2'b01; return; end
      m_run = run_after;
      if (op == T_R || op == T_I) begin
         push(1'b0, mk(0, 0, 0, op == T_I, alu_exp(f3, f7[5], op == T_R), 0, 0, 1, 0, 2'b00));
         push(1'b0, mk(0, 0, 0, 0, 4'd0, 1, 0, 1, 0, 2'b00));
      end else begin
         push(1'b0, mk(0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 2'b00));
         push_mem(1'b0, op == T_ST, md, to);
         if (to) begin tc = 2'b10; return; end
         if (op == T_LD) push(1'b0, mk(0, 0, 0, 0, 4'd0, 1, 1, 1, 0, 2'b00));
      end
      m_ret = (m_ret + 1) % (1 << CW);
   endtask

   task automatic run_q(input string tag);
      step_t       s;
      logic [14:0] obs;
      int unsigned cyc;
      cyc = 0;
      while (q.size() > 0) begin
         s = q.pop_front();
         @(negedge clk);
         rst = s.rst; bus.run = s.run; bus.mem_ready = s.rdy;
         bus.op = s.op; bus.func3 = s.f3; bus.func7 = s.f7;
         #1;
         obs = {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.alu_src_imm,
                bus.alu_ctrl, bus.reg_write, bus.wb_sel, bus.busy, bus.halt, bus.cause};
         n_total++;
         assert (obs === s.out) n_pass++;
         else $error("FAIL %s cyc %0d ctl: got %h expected %h", tag, cyc, obs, s.out);
         n_total++;
         assert (bus.retired === s.ret) n_pass++;
         else $error("FAIL %s cyc %0d retired: got %0d expected %0d", tag, cyc, bus.retired, s.ret);
         cyc++;
      end
   endtask

   initial begin
      logic [1:0] tc;
      logic [6:0] rop;
      logic       ra;
      int         kind, sel, fd, md;

      rst = 1'b1; bus.run = 1'b0; bus.mem_ready = 1'b0;
      bus.op = '0; bus.func3 = '0; bus.func7 = '0;
      @(posedge clk);

      // Reset state, then an R-type SUB with immediate memory.
      m_run = 1'b0;
      push(1'b0, '0);
      mark_reset();
      start_from_idle();
      gen_instr(T_R, 3'b000, 7'b0100000, 0, 0, 1'b0, tc);
      push_idle(2);
      run_q("t1_rtype");

      // Load with three wait cycles in MEM_RD.
      start_from_idle();
      gen_instr(T_LD, 3'b010, 7'b0000000, 0, 3, 1'b0, tc);
      push_idle(1);
      run_q("t2_load");

      // Store.
      start_from_idle();
      gen_instr(T_ST, 3'b010, 7'b0000000, 1, 2, 1'b0, tc);
      push_idle(1);
      run_q("t3_store");

      // Illegal opcode: sticky trap, then reset.
      start_from_idle();
      gen_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0, 1'b0, tc);
      push_trap(20, tc);
      mark_reset();
      m_run = 1'b0;
      push_idle(2);
      run_q("t4_illegal");

      // Fetch timeout, then ready on the last allowed cycle.
      start_from_idle();
      gen_instr(T_R, 3'b111, 7'b0000000, TMO, 0, 1'b0, tc);
      push_trap(3, tc);
      mark_reset();
      m_run = 1'b0;
      push_idle(1);
      start_from_idle();
      gen_instr(T_I, 3'b110, 7'b0000000, TMO - 1, 0, 1'b0, tc);
      push_idle(1);
      run_q("t5_fetch_tmo");

      // Load timeout and store completing on the last allowed cycle.
      start_from_idle();
      gen_instr(T_ST, 3'b000, 7'b0000000, 0, TMO - 1, 1'b0, tc);
      push_idle(1);
      start_from_idle();
      gen_instr(T_LD, 3'b000, 7'b0000000, 0, TMO, 1'b0, tc);
      push_trap(2, tc);
      mark_reset();
      m_run = 1'b0;
      push_idle(1);
      run_q("t5_mem_tmo");

      // run dropped during EXEC_I (SRAI), then rst in the middle of MEM_RD.
      start_from_idle();
      gen_instr(T_I, 3'b101, 7'b0100000, 0, 0, 1'b0, tc);
      push_idle(2);
      start_from_idle();
      m_op = T_LD; m_f3 = 3'b010; m_f7 = '0;
      push_mem(1'b1, 1'b0, 0, ra);
      push(1'b0, mk(0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 2'b00));
      push(1'b0, mk(0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 2'b00));
      push(1'b0, mk(1, 0, 0, 0, 4'd0, 0, 0, 1, 0, 2'b00));
      push(1'b0, mk(1, 0, 0, 0, 4'd0, 0, 0, 1, 0, 2'b00));
      mark_reset();
      m_run = 1'b0;
      push_idle(2);
      run_q("t6_run_rst");

      // Back-to-back R-types across the retired-counter wrap.
      start_from_idle();
      for (int i = 0; i < 17; i++)
         gen_instr(T_R, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 0, 0, i < 16, tc);
      push_idle(1);
      run_q("t7_wrap");

      // Randomised instruction stream.
      start_from_idle();
      for (int unsigned i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         if (kind < 2)      rop = T_R;
         else if (kind < 4) rop = T_I;
         else if (kind < 6) rop = T_LD;
         else if (kind < 8) rop = T_ST;
         else if (kind < 9) begin
            rop = 7'($urandom_range(0, 127));
            while (is_legal(rop)) rop = 7'($urandom_range(0, 127));
         end else rop = T_R;
         sel = $urandom_range(0, 11);
         fd  = (sel < 9) ? $urandom_range(0, 3) : (sel == 9) ? TMO - 1 : (sel == 10) ? TMO : 2;
         sel = $urandom_range(0, 11);
         md  = (sel < 9) ? $urandom_range(0, 3) : (sel == 9) ? TMO - 1 : (sel == 10) ? TMO : 1;
         ra  = ($urandom_range(0, 3) != 0);
         gen_instr(rop, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), fd, md, ra, tc);
         if (tc != 2'b00) begin
            push_trap($urandom_range(1, 4), tc);
            mark_reset();
            m_run = 1'b0;
            push_idle(1);
            start_from_idle();
         end else if (!ra) begin
            m_run = 1'b0;
            push_idle($urandom_range(0, 2));
            start_from_idle();
         end
      end
      run_q("random");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
